button_debounce_sched: RTL and testbench

BUTTON_DEBOUNCE_SCHED -- requirements
Module: button_debounce_sched

---
 rtl/button_debounce_sched.sv | 118 +++++++++++
 tb/tb_button_debounce_sched.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/button_debounce_sched.sv
// Debounces NUM_BUTTONS synchronized inputs with a single shared counter.
// A round-robin scheduler grants the counter to one mismatched button at a time.
module button_debounce_sched #(
  parameter int NUM_BUTTONS    = 4,
  parameter int DEBOUNCE_LIMIT = 20
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic [NUM_BUTTONS-1:0] i_Buttons,
  output logic [NUM_BUTTONS-1:0] o_Filtered,
  output logic [NUM_BUTTONS-1:0] o_Press,
  output logic [NUM_BUTTONS-1:0] o_Release,
  output logic [NUM_BUTTONS-1:0] o_Grant,
  output logic                   o_Busy
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT);
  localparam int PW = $clog2(NUM_BUTTONS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_LIMIT - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(NUM_BUTTONS - 1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t                 r_State, w_State;
  logic [CW-1:0]          r_Count, w_Count;
  logic [PW-1:0]          r_Ptr, w_Ptr;
  logic [PW-1:0]          r_Idx, w_Idx;
  logic [NUM_BUTTONS-1:0] r_Filtered, w_Filtered;
  logic [NUM_BUTTONS-1:0] r_Press, w_Press;
  logic [NUM_BUTTONS-1:0] r_Release, w_Release;

  logic [NUM_BUTTONS-1:0] w_Mismatch;
  logic                   w_Found;
  logic [PW-1:0]          w_Sel;
  logic [PW-1:0]          w_IdxNext;
  logic [PW-1:0]          w_Cand;

  assign w_Mismatch = i_Buttons ^ r_Filtered;
  assign w_IdxNext  = (r_Idx == IDX_LAST) ? '0 : r_Idx + PW'(1);

  // Search starts at the pointer and wraps, so the first hit is the
  // lowest mismatched index at or above the pointer.
  always_comb begin
    w_Found = 1'b0;
    w_Sel   = '0;
    w_Cand  = '0;
    for (int unsigned k = 0; k < NUM_BUTTONS; k++) begin
      w_Cand = PW'((int'(r_Ptr) + int'(k)) % NUM_BUTTONS);
      if (!w_Found && w_Mismatch[w_Cand]) begin
        w_Found = 1'b1;
        w_Sel   = w_Cand;
      end
    end
  end

  always_comb begin
    w_State    = r_State;
    w_Count    = r_Count;
    w_Ptr      = r_Ptr;
    w_Idx      = r_Idx;
    w_Filtered = r_Filtered;
    w_Press    = '0;
    w_Release  = '0;
    case (r_State)
      IDLE: begin
        w_Count = '0;
        if (w_Found) begin
          w_Idx   = w_Sel;
          w_State = COUNT;
        end
      end
      COUNT: begin
        if (!w_Mismatch[r_Idx]) begin
          w_Count = '0;
          w_Ptr   = w_IdxNext;
          w_State = IDLE;
        end else if (r_Count == CNT_MAX) begin
          w_Filtered[r_Idx] = ~r_Filtered[r_Idx];
          if (i_Buttons[r_Idx]) w_Press[r_Idx]   = 1'b1;
          else                  w_Release[r_Idx] = 1'b1;
          w_Count = '0;
          w_Ptr   = w_IdxNext;
          w_State = IDLE;
        end else begin
          w_Count = r_Count + CW'(1);
        end
      end
      default: w_State = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State    <= IDLE;
      r_Count    <= '0;
      r_Ptr      <= '0;
      r_Idx      <= '0;
      r_Filtered <= '0;
      r_Press    <= '0;
      r_Release  <= '0;
    end else begin
      r_State    <= w_State;
      r_Count    <= w_Count;
      r_Ptr      <= w_Ptr;
      r_Idx      <= w_Idx;
      r_Filtered <= w_Filtered;
      r_Press    <= w_Press;
      r_Release  <= w_Release;
    end
  end

  assign o_Filtered = r_Filtered;
  assign o_Press    = r_Press;
  assign o_Release  = r_Release;
  assign o_Busy     = (r_State == COUNT);
  assign o_Grant    = o_Busy ? (NUM_BUTTONS'(1) << r_Idx) : '0;

endmodule

// File: tb/tb_button_debounce_sched.sv
// Directed scenarios plus random button activity, compared every cycle
// against a time-stamp based reference model of the scheduler.
module tb_button_debounce_sched;

  localparam int N = 4;
  localparam int L = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] filt, press, rel, grant;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  logic [N-1:0] m_filt, m_press, m_rel;
  int           m_busy, m_gidx, m_ptr, m_start;

  button_debounce_sched #(.NUM_BUTTONS(N), .DEBOUNCE_LIMIT(L)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Buttons(btn),
    .o_Filtered(filt), .o_Press(press), .o_Release(rel),
    .o_Grant(grant), .o_Busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // A grant made at tick t commits at tick t+L unless the button agrees
  // with its filtered level at some earlier tick.
  task automatic model_step(input logic r, input logic [N-1:0] b);
    m_press = '0;
    m_rel   = '0;
    if (r) begin
      m_filt = '0; m_busy = 0; m_gidx = 0; m_ptr = 0;
    end else if (m_busy == 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_busy == 0 && b[idx] != m_filt[idx]) begin
          m_busy = 1; m_gidx = idx; m_start = cyc;
        end
      end
    end else if (b[m_gidx] == m_filt[m_gidx]) begin
      m_busy = 0; m_ptr = (m_gidx + 1) % N;
    end else if (cyc - m_start == L) begin
      m_filt[m_gidx] = b[m_gidx];
      if (b[m_gidx]) m_press[m_gidx] = 1'b1;
      else           m_rel[m_gidx]   = 1'b1;
      m_busy = 0; m_ptr = (m_gidx + 1) % N;
    end
  endtask

  task automatic tick(input logic r, input logic [N-1:0] b);
    logic [N-1:0] m_grant;
    rst = r;
    btn = b;
    @(posedge clk);
    cyc++;
    model_step(r, b);
    #1;
    m_grant = (m_busy != 0) ? (N'(1) << m_gidx) : '0;
    check("filtered", 32'(filt), 32'(m_filt));
    check("press",    32'(press), 32'(m_press));
    check("release",  32'(rel), 32'(m_rel));
    check("grant",    32'(grant), 32'(m_grant));
    check("busy",     32'(busy), 32'(m_busy != 0));
  endtask

  // ticks with inputs held until any bit of sel rises on the chosen output
  task automatic run_until(input logic [N-1:0] b, input int which, input logic [N-1:0] sel,
                           input int budget, output int n);
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      tick(1'b0, b);
      n++;
      case (which)
        0: hit = |(press & sel);
        1: hit = |(rel & sel);
        2: hit = |(grant & sel);
        default: hit = |(filt & sel);
      endcase
    end
    if (!hit) check("timeout", 32'(n), 32'(budget + 1));
  endtask

  initial begin
    int n, t0, npress;
    logic [N-1:0] rb;
    m_filt = '0; m_press = '0; m_rel = '0;
    m_busy = 0; m_gidx = 0; m_ptr = 0; m_start = 0;
    rst = 1'b1;
    btn = '0;
    repeat (3) tick(1'b1, '0);
    check("reset_outputs", {filt, press, rel, grant, busy}, '0);

    // clean press: grant next cycle, commit L ticks after grant edge
    tick(1'b0, 4'b0001);
    check("clean_grant", 32'(grant), 32'h1);
    run_until(4'b0001, 0, 4'b0001, 40, n);
    check("clean_latency", n, L);
    check("clean_press", 32'(press), 32'h1);
    tick(1'b0, 4'b0001);
    check("clean_press_one_cycle", 32'(press), 32'h0);

    // release
    tick(1'b0, 4'b0000);
    run_until(4'b0000, 1, 4'b0001, 40, n);
    check("release_latency", n, L);
    check("release_filtered", 32'(filt), 32'h0);

    // bounce on bit 1: abort then one clean commit
    npress = 0;
    repeat (7) tick(1'b0, 4'b0010);
    tick(1'b0, 4'b0000);
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 4'b0010);
      if (press[1]) npress++;
    end
    check("bounce_one_press", npress, 1);
    repeat (2) tick(1'b0, 4'b0000);
    run_until(4'b0000, 1, 4'b0010, 40, n);

    // contention from reset: bit 0 then bit 2, 21 ticks apart
    repeat (2) tick(1'b1, '0);
    run_until(4'b0101, 3, 4'b0001, 40, n);
    t0 = cyc;
    run_until(4'b0101, 3, 4'b0100, 40, n);
    check("contention_gap", cyc - t0, L + 1);
    check("contention_filtered", 32'(filt), 32'h5);

    // pointer now at 3: bits 3 and 0 mismatched -> 3 first, then 0
    tick(1'b0, 4'b1100);
    check("wrap_first", 32'(grant), 32'h8);
    run_until(4'b1100, 2, 4'b0001, 40, n);
    check("wrap_second", 32'(grant), 32'h1);

    // reset while counter is at 10
    repeat (2) tick(1'b1, '0);
    tick(1'b0, 4'b0001);
    repeat (10) tick(1'b0, 4'b0001);
    tick(1'b1, 4'b0001);
    check("midcount_reset", {filt, press, rel, grant, busy}, '0);
    tick(1'b0, 4'b0001);
    run_until(4'b0001, 0, 4'b0001, 40, n);
    check("restart_latency", n, L);

    // random activity
    rb = btn;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rb[$urandom_range(0, N - 1)] ^= 1'b1;
      tick($urandom_range(0, 999) == 0, rb);
      if ($countones(press | rel) > 1) check("one_pulse", $countones(press | rel), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
